mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between instruction fetch (IF) and data access (LDR/STR from EX/MEM).
- Sequences each access through a fixed wait-state counter and returns ack and read data.
- Produces per-requester stall qualifiers for the stall controller.
- Sits between the fetch unit / data-address path and the memory macro; replaces the static address-mode mux for memory ownership.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_wait_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the in-flight access
//   WAIT_W      : width of the wait-state counter (WAIT_CYCLES 0..15)
//   STARVE_W    : width of the fetch-starvation counter (STARVE_MAX 1..15)
package mem_arb_pkg;

    localparam int WAIT_MAX_CFG   = 15;
    localparam int STARVE_MAX_CFG = 15;
    localparam int WAIT_W         = $clog2(WAIT_MAX_CFG + 1);
    localparam int STARVE_W       = $clog2(STARVE_MAX_CFG + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Owner of the access implied by a BUSY state.
    function automatic owner_t state_owner(input arb_state_t s);
        return (s == BUSY_IF) ? OWN_IF : OWN_D;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to time memory wait states.
//   clk, rst    : clock, synchronous active-low reset
//   i_load      : load i_load_val (has priority over decrement)
//   i_load_val  : value to load
//   i_dec       : decrement by one, holds at zero
//   o_zero      : counter currently equals zero
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port unified memory between instruction fetch
// and data (load/store) accesses. Each access is held on the memory port for
// WAIT_CYCLES+1 cycles, then the owner receives a one-cycle ack together with
// registered read data.
//   clk, rst                         : clock, synchronous active-low reset
//   i_if_req / i_if_addr             : fetch request and address
//   i_d_req / i_d_we / i_d_addr /
//   i_d_wdata                        : data request, store flag, address, store data
//   o_if_ack / o_d_ack / o_rdata     : completion pulses and read data
//   o_stall_if / o_stall_d           : combinational stall qualifiers
//   o_mem_en / o_mem_we / o_mem_addr /
//   o_mem_wdata / i_mem_rdata        : memory macro interface
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_if_ack,
    output logic          o_d_ack,
    output logic [DW-1:0] o_rdata,
    output logic          o_stall_if,
    output logic          o_stall_d,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(WAIT_CYCLES);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;

    logic   wait_load, wait_dec, wait_zero;
    logic   grant_if, grant_d;
    owner_t owner;

    // Data normally wins (it belongs to the older instruction); fetch is
    // forced through once it has been passed over STARVE_MAX times in a row.
    assign grant_if = i_if_req && (!i_d_req || (starve_q == STARVE_LIM));
    assign grant_d  = i_d_req && !grant_if;
    assign owner    = state_owner(state_q);

    mem_wait_counter #(
        .W (WAIT_W)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .i_load     (wait_load),
        .i_load_val (WAIT_INIT),
        .i_dec      (wait_dec),
        .o_zero     (wait_zero)
    );

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        wait_load   = 1'b0;
        wait_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d    = BUSY_IF;
                    starve_d   = '0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_if_addr;
                    wait_load  = 1'b1;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = i_d_we;
                    mem_addr_d  = i_d_addr;
                    mem_wdata_d = i_d_wdata;
                    wait_load   = 1'b1;
                    // Only data grants that bypass a waiting fetch count
                    // towards starvation.
                    if (i_if_req) begin
                        starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM
                                                            : starve_q + STARVE_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                if (wait_zero) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // Stores leave the read-data register untouched.
                    if ((owner == OWN_IF) || !mem_we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                    if_ack_d = (owner == OWN_IF);
                    d_ack_d  = (owner == OWN_D);
                end else begin
                    wait_dec = 1'b1;
                end
            end
            DONE: begin
                // Requests seen in the ack cycle are stale; re-arbitrate next cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign o_if_ack    = if_ack_q;
    assign o_d_ack     = d_ack_q;
    assign o_rdata     = rdata_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_stall_if  = i_if_req & ~if_ack_q;
    assign o_stall_d   = i_d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance with WAIT_CYCLES=1 and
// STARVE_MAX=4 for the directed scenarios, a second with WAIT_CYCLES=0 for
// back-to-back fetch timing. Acks are checked against a queue of expected
// (owner, read data) entries pushed as requests are issued.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance (WAIT_CYCLES=1)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ack, d_ack, stall_if, stall_d, mem_en, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    // Second instance (WAIT_CYCLES=0), fetch port only
    logic        if_req0 = 1'b0;
    logic [15:0] if_addr0 = '0;
    logic        if_ack0, d_ack0, stall_if0, stall_d0, mem_en0, mem_we0;
    logic [15:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;

    mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_if_ack(if_ack), .o_d_ack(d_ack), .o_rdata(rdata),
        .o_stall_if(stall_if), .o_stall_d(stall_d),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(0), .STARVE_MAX(4)) dut0 (
        .clk(clk), .rst(rst),
        .i_if_req(if_req0), .i_if_addr(if_addr0),
        .i_d_req(1'b0), .i_d_we(1'b0), .i_d_addr(16'h0000), .i_d_wdata(16'h0000),
        .o_if_ack(if_ack0), .o_d_ack(d_ack0), .o_rdata(rdata0),
        .o_stall_if(stall_if0), .o_stall_d(stall_d0),
        .o_mem_en(mem_en0), .o_mem_we(mem_we0), .o_mem_addr(mem_addr0),
        .o_mem_wdata(mem_wdata0), .i_mem_rdata(mem_rdata0)
    );

    // Memory model: 256 words indexed by the low address byte, async read.
    logic [15:0] bmem [256];
    assign mem_rdata  = bmem[mem_addr[7:0]];
    assign mem_rdata0 = ~mem_addr0;

    always @(posedge clk) begin
        if (!rst) begin
            bmem[8'h10] <= 16'hB510;
            bmem[8'h00] <= 16'h1234;
        end else if (mem_en && mem_we) begin
            bmem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic        is_d;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the main instance.
    exp_t mon_e;
    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            check("ack_expected", 32'(sb_q.size() != 0), 32'd1);
            check("single_ack", 32'(if_ack & d_ack), 32'd0);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("ack_owner_is_d", 32'(d_ack), 32'(mon_e.is_d));
                check("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
                $display("txn %s ack rdata=0x%04h at %0t", d_ack ? "D " : "IF", rdata, $time);
            end
        end
    end

    // Requesters must hold req while stalled (withdrawal mid-access is illegal).
    logic prev_stall_d = 1'b0, prev_stall_if = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            assert (!(prev_stall_d && !d_req)) else $error("protocol: d_req withdrawn while stalled");
            assert (!(prev_stall_if && !if_req)) else $error("protocol: if_req withdrawn while stalled");
        end
        prev_stall_d  <= stall_d && rst;
        prev_stall_if <= stall_if && rst;
    end

    // Wait (bounded) for an ack on the main instance, then step into the
    // following cycle so the caller can change its request.
    task automatic wait_ack(input bit want_d, input int budget);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = want_d ? d_ack : if_ack;
        end
        check(want_d ? "wait_d_ack" : "wait_if_ack", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst0_mem_en", 32'(mem_en0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- fetch only, cycle-accurate ----------------
        if_req  = 1'b1;
        if_addr = 16'h0010;
        sb_q.push_back('{is_d: 1'b0, rdata: 16'hB510});
        @(negedge clk);  // cycle 0: grant
        check("f_c0_stall_if", 32'(stall_if), 32'd1);
        check("f_c0_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);  // cycle 1
        check("f_c1_mem_en", 32'(mem_en), 32'd1);
        check("f_c1_mem_addr", 32'(mem_addr), 32'h0010);
        check("f_c1_mem_we", 32'(mem_we), 32'd0);
        check("f_c1_stall_if", 32'(stall_if), 32'd1);
        @(negedge clk);  // cycle 2
        check("f_c2_mem_en", 32'(mem_en), 32'd1);
        check("f_c2_if_ack", 32'(if_ack), 32'd0);
        check("f_c2_stall_if", 32'(stall_if), 32'd1);
        @(negedge clk);  // cycle 3: ack
        check("f_c3_if_ack", 32'(if_ack), 32'd1);
        check("f_c3_rdata", 32'(rdata), 32'hB510);
        check("f_c3_stall_if", 32'(stall_if), 32'd0);
        check("f_c3_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;

        // ---------------- simultaneous IF + D load ----------------
        if_req = 1'b1; if_addr = 16'h0010;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h2000;
        sb_q.push_back('{is_d: 1'b1, rdata: 16'h1234});
        sb_q.push_back('{is_d: 1'b0, rdata: 16'hB510});
        @(negedge clk);
        check("sim_stall_d", 32'(stall_d), 32'd1);
        check("sim_stall_if", 32'(stall_if), 32'd1);
        wait_ack(1'b1, 10);
        d_req = 1'b0;
        @(negedge clk);  // IDLE after DONE: fetch granted here
        check("sim_grant_cycle_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("sim_if_mem_en", 32'(mem_en), 32'd1);
        check("sim_if_mem_addr", 32'(mem_addr), 32'h0010);
        wait_ack(1'b0, 10);
        if_req = 1'b0;

        // ---------------- store ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h2004; d_wdata = 16'hBEEF;
        sb_q.push_back('{is_d: 1'b1, rdata: 16'hB510});  // rdata unchanged
        @(negedge clk);
        check("st_grant_mem_en", 32'(mem_en), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("st_mem_en", 32'(mem_en), 32'd1);
            check("st_mem_we", 32'(mem_we), 32'd1);
            check("st_mem_addr", 32'(mem_addr), 32'h2004);
            check("st_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        end
        wait_ack(1'b1, 5);
        check("st_after_mem_we", 32'(mem_we), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        // load back the stored word
        d_req = 1'b1; d_addr = 16'h2004;
        sb_q.push_back('{is_d: 1'b1, rdata: 16'hBEEF});
        wait_ack(1'b1, 10);
        d_req = 1'b0;

        // ---------------- starvation (STARVE_MAX=4) ----------------
        if_req = 1'b1; if_addr = 16'h0010;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h2000;
        for (int i = 0; i < 4; i++) sb_q.push_back('{is_d: 1'b1, rdata: 16'h1234});
        sb_q.push_back('{is_d: 1'b0, rdata: 16'hB510});
        for (int i = 0; i < 2; i++) sb_q.push_back('{is_d: 1'b1, rdata: 16'h1234});
        for (int i = 0; i < 4; i++) wait_ack(1'b1, 10);
        wait_ack(1'b0, 10);
        if_req = 1'b0;
        for (int i = 0; i < 2; i++) wait_ack(1'b1, 10);
        d_req = 1'b0;
        check("starve_sb_drained", 32'(sb_q.size()), 32'd0);

        // ---------------- reset in the middle of a data access ----------------
        d_req = 1'b1; d_addr = 16'h2000;  // granted this cycle, never acked
        @(posedge clk); #1;               // now in BUSY_D
        rst   = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mrst_mem_en", 32'(mem_en), 32'd0);
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_d_ack", 32'(d_ack), 32'd0);
        check("mrst_rdata", 32'(rdata), 32'd0);
        check("mrst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        check("mrst_stall_if", 32'(stall_if), 32'd1);
        check("mrst_no_ack", 32'(if_ack | d_ack), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.push_back('{is_d: 1'b0, rdata: 16'hB510});
        wait_ack(1'b0, 10);
        if_req = 1'b0;

        // ---------------- WAIT_CYCLES=0 back-to-back fetches ----------------
        if_req0  = 1'b1;
        if_addr0 = 16'h0044;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);  // IDLE: grant
            check("w0_idle_ack", 32'(if_ack0), 32'd0);
            check("w0_idle_en", 32'(mem_en0), 32'd0);
            @(negedge clk);  // BUSY
            check("w0_busy_ack", 32'(if_ack0), 32'd0);
            check("w0_busy_en", 32'(mem_en0), 32'd1);
            check("w0_busy_addr", 32'(mem_addr0), 32'h0044);
            @(negedge clk);  // DONE: ack, no new grant
            check("w0_done_ack", 32'(if_ack0), 32'd1);
            check("w0_done_en", 32'(mem_en0), 32'd0);
            check("w0_done_rdata", 32'(rdata0), 32'hFFBB);
            $display("txn W0 IF ack %0d rdata=0x%04h at %0t", k, rdata0, $time);
        end
        @(posedge clk); #1;
        if_req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w0_quiet_en", 32'(mem_en0), 32'd0);
        check("w0_quiet_ack", 32'(if_ack0), 32'd0);

        check("final_sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
